// File: rtl/aes_inv_keyexpansion_192.sv
// AES-192 round-key generator for the inverse cipher: expands the key forward to
// w[42..53], then walks the schedule backwards presenting round keys 12 down to 0.
module aes_inv_keyexpansion_192 #(
  parameter int NR = 12,
  parameter int NK = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [191:0] short_key,
  output logic [127:0] subkey,
  output logic [3:0]   cnt192,
  output logic         valid_skey,
  input  logic         skey_ready,
  output logic         busy
);

  localparam logic [2:0] FWD_LAST   = 3'((4 * (NR + 1)) / NK - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  state_t      state_q, state_d;
  logic [31:0] words_q [12];
  logic [3:0]  round_q;
  logic [2:0]  step_q;
  logic [5:0]  base, four_r, offset;
  logic        in_window;
  logic [31:0] fwd_w [6];
  logic [31:0] rev_w [6];
  logic [31:0] prev_tail, sub_in, sub_out, acc;
  logic [2:0]  rcon_shift;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] x, input logic [2:0] rc_shift);
    logic [7:0] rc;
    rc = 8'h01 << rc_shift;
    return {sbox(x[23:16]) ^ rc, sbox(x[15:8]), sbox(x[7:0]), sbox(x[31:24])};
  endfunction

  // The buffer holds w[base..base+11]; base is six words per step of step_q.
  always_comb begin
    base      = ({3'b000, step_q} << 2) + ({3'b000, step_q} << 1);
    four_r    = {round_q, 2'b00};
    offset    = four_r - base;
    in_window = four_r >= base;
  end

  // One SubWord unit is shared: FWD feeds w[i-1] of the newest period, REV feeds the
  // reconstructed w[base-1] so the oldest word of the previous period can be recovered.
  always_comb begin
    prev_tail = words_q[5] ^ words_q[4];
    for (int j = 1; j < 6; j++) rev_w[j] = words_q[j] ^ words_q[j-1];
    sub_in     = (state_q == FWD) ? words_q[11] : prev_tail;
    rcon_shift = (state_q == FWD) ? step_q : step_q - 3'd1;
    sub_out    = sub_rot_word(sub_in, rcon_shift);
    rev_w[0]   = words_q[0] ^ sub_out;
    acc        = words_q[6] ^ sub_out;
    fwd_w[0]   = acc;
    for (int j = 1; j < 6; j++) begin
      acc      = words_q[6+j] ^ acc;
      fwd_w[j] = acc;
    end
  end

  always_comb begin
    valid_skey = (state_q == REV) && in_window;
    subkey     = '0;
    cnt192     = '0;
    if (valid_skey) begin
      cnt192 = round_q;
      case (offset)
        6'd0:    subkey = {words_q[0], words_q[1], words_q[2], words_q[3]};
        6'd2:    subkey = {words_q[2], words_q[3], words_q[4], words_q[5]};
        6'd4:    subkey = {words_q[4], words_q[5], words_q[6], words_q[7]};
        6'd6:    subkey = {words_q[6], words_q[7], words_q[8], words_q[9]};
        default: subkey = '0;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FWD;
      FWD:     if (step_q == FWD_LAST) state_d = REV;
      REV:     if (valid_skey && skey_ready && round_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      for (int j = 0; j < 12; j++) words_q[j] <= '0;
      round_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int j = 0; j < 6; j++) words_q[6+j] <= short_key[191-32*j -: 32];
            step_q <= '0;
          end
        end
        FWD: begin
          for (int j = 0; j < 6; j++) begin
            words_q[j]   <= words_q[6+j];
            words_q[6+j] <= fwd_w[j];
          end
          if (step_q == FWD_LAST) round_q <= LAST_ROUND;
          else                    step_q  <= step_q + 3'd1;
        end
        REV: begin
          if (in_window) begin
            if (skey_ready && round_q != 4'd0) round_q <= round_q - 4'd1;
          end else begin
            for (int j = 0; j < 6; j++) begin
              words_q[6+j] <= words_q[j];
              words_q[j]   <= rev_w[j];
            end
            step_q <= step_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_keyexpansion_192.sv
// Scoreboard bench: a forward FIPS-197 model with an arithmetic S-box predicts every
// round key and the valid/step pattern, and the monitor compares on each accept.
module tb_aes_inv_keyexpansion_192;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [191:0] short_key;
  logic [127:0] subkey;
  logic [3:0]   cnt192;
  logic         valid_skey;
  logic         skey_ready;
  logic         busy;

  aes_inv_keyexpansion_192 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .short_key  (short_key),
    .subkey     (subkey),
    .cnt192     (cnt192),
    .valid_skey (valid_skey),
    .skey_ready (skey_ready),
    .busy       (busy)
  );

  typedef struct {
    logic [3:0]   cnt;
    logic [127:0] key;
  } exp_t;

  exp_t        sbQ[$];
  bit          expPat[$];
  bit          traceQ[$];
  logic [31:0] modelW [54];
  int          checks = 0;
  int          errors = 0;
  int          acceptCount = 0;
  bit          readyRandom = 0;
  bit          prevStalled = 0;
  logic [127:0] prevKey;
  logic [3:0]  prevCnt;
  exp_t        monE;

  localparam logic [191:0] KEY_A = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [191:0] KEY_B = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 0; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sboxRef(input logic [7:0] x);
    logic [7:0] inv;
    inv = 0;
    if (x != 0)
      for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic void buildWords(input logic [191:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 6; i++) modelW[i] = key[191-32*i -: 32];
    for (int i = 6; i < 54; i++) begin
      t = modelW[i-1];
      if (i % 6 == 0) begin
        rc = 8'h01;
        for (int k = 1; k < i / 6; k++) rc = gmul(rc, 8'h02);
        t = {sboxRef(t[23:16]) ^ rc, sboxRef(t[15:8]), sboxRef(t[7:0]), sboxRef(t[31:24])};
      end
      modelW[i] = modelW[i-6] ^ t;
    end
  endfunction

  // Expected keys go to the scoreboard; expPat records the busy-cycle valid pattern.
  function automatic void pushExpected(input logic [191:0] key);
    exp_t e;
    int   b;
    buildWords(key);
    expPat.delete();
    for (int k = 0; k < 8; k++) expPat.push_back(1'b0);
    b = 42;
    for (int r = 12; r >= 0; r--) begin
      e.cnt = 4'(r);
      e.key = {modelW[4*r], modelW[4*r+1], modelW[4*r+2], modelW[4*r+3]};
      sbQ.push_back(e);
      while (4 * r < b) begin
        expPat.push_back(1'b0);
        b -= 6;
      end
      expPat.push_back(1'b1);
    end
  endfunction

  task automatic applyStimulus(input logic [191:0] key, input bit expectKeys);
    if (expectKeys) pushExpected(key);
    short_key = key;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("idleTimeout", 128'(busy), 128'd0);
    checkOutput("allAccepted", 128'(sbQ.size()), 128'd0);
  endtask

  always @(posedge clk) begin
    #1;
    skey_ready = readyRandom ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prevStalled = 0;
    end else begin
      if (prevStalled) begin
        checkOutput("stallValid", 128'(valid_skey), 128'd1);
        checkOutput("stallKey", subkey, prevKey);
        checkOutput("stallCnt", 128'(cnt192), 128'(prevCnt));
      end
      if (!valid_skey) checkOutput("zeroWhenInvalid", subkey | 128'(cnt192), 128'd0);
      if (valid_skey && skey_ready) begin
        acceptCount++;
        if (sbQ.size() == 0) begin
          checkOutput("extraKey", 128'(sbQ.size()), 128'd1);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("cnt192", 128'(cnt192), 128'(monE.cnt));
          checkOutput("subkey", subkey, monE.key);
        end
      end
      prevStalled = valid_skey && !skey_ready;
      prevKey = subkey;
      prevCnt = cnt192;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int firstValid, busyCycles, edgeNo, n, accBefore;
    logic [127:0] traceVec, patVec;
    clk = 0; reset_n = 0; start = 0; short_key = '0; skey_ready = 1;
    #12;
    checkOutput("resetValid", 128'(valid_skey), 128'd0);
    checkOutput("resetKey", subkey, 128'd0);
    checkOutput("resetCnt", 128'(cnt192), 128'd0);
    checkOutput("resetBusy", 128'(busy), 128'd0);
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;

    $display("[TB] run with ready high, latency and sequence");
    applyStimulus(KEY_A, 1);
    firstValid = 0; busyCycles = 0; edgeNo = 1; traceQ.delete();
    for (int k = 0; k < 80; k++) begin
      if (!busy) break;
      busyCycles++;
      traceQ.push_back(valid_skey);
      if (valid_skey && firstValid == 0) begin
        firstValid = edgeNo;
        checkOutput("firstCnt", 128'(cnt192), 128'd12);
        checkOutput("firstKey", subkey, 128'he98ba06f448c773c8ecc720401002202);
      end
      if (valid_skey && cnt192 == 4'd1) checkOutput("key1", subkey, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
      if (valid_skey && cnt192 == 4'd0) checkOutput("key0", subkey, 128'h8e73b0f7da0e6452c810f32b809079e5);
      @(posedge clk); #1;
      edgeNo++;
    end
    checkOutput("firstValidEdge", 128'(firstValid), 128'd9);
    checkOutput("busyCycles", 128'(busyCycles), 128'd28);
    traceVec = '0; patVec = '0;
    foreach (traceQ[i]) traceVec = (traceVec << 1) | 128'(traceQ[i]);
    foreach (expPat[i]) patVec = (patVec << 1) | 128'(expPat[i]);
    checkOutput("validTrace", traceVec, patVec);
    checkOutput("endValid", 128'(valid_skey), 128'd0);
    waitIdle(10);

    $display("[TB] random backpressure");
    readyRandom = 1;
    accBefore = acceptCount;
    applyStimulus(KEY_A, 1);
    waitIdle(600);
    checkOutput("acceptCount", 128'(acceptCount - accBefore), 128'd13);
    readyRandom = 0;
    @(posedge clk); #1;

    $display("[TB] start during REV is ignored");
    applyStimulus(KEY_A, 1);
    n = 0;
    while (!valid_skey && n < 40) begin @(posedge clk); #1; n++; end
    short_key = KEY_B;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitIdle(60);
    @(posedge clk); #1;
    checkOutput("noRestart", 128'(busy), 128'd0);

    $display("[TB] reset during REV");
    applyStimulus(KEY_A, 1);
    n = 0;
    while (!(valid_skey && cnt192 == 4'd7) && n < 60) begin @(posedge clk); #1; n++; end
    checkOutput("reachCnt7", 128'(cnt192), 128'd7);
    reset_n = 0;
    #1;
    checkOutput("abortValid", 128'(valid_skey), 128'd0);
    checkOutput("abortKey", subkey, 128'd0);
    checkOutput("abortBusy", 128'(busy), 128'd0);
    checkOutput("abortCnt", 128'(cnt192), 128'd0);
    sbQ.delete();
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    applyStimulus(KEY_A, 1);
    n = 0;
    while (!valid_skey && n < 40) begin @(posedge clk); #1; n++; end
    checkOutput("restartCnt", 128'(cnt192), 128'd12);
    checkOutput("restartKey", subkey, 128'he98ba06f448c773c8ecc720401002202);
    waitIdle(60);

    $display("[TB] all-zero key");
    applyStimulus(192'd0, 1);
    waitIdle(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
